prim_alert_link_skew: RTL and testbench



---
 rtl/prim_alert_link_skew.sv | 137 +++++++++++++
 tb/tb_prim_alert_link_skew.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_alert_link_skew.sv
// prim_alert_link_skew
//   Multi-channel model of the differential alert link that sits between
//   the alert sender and receiver arrays. Every wire of every channel is
//   delayed by a runtime-selectable 1..MaxSkew+1 cycles, and each output
//   can be inverted for error injection. An optional monitor flags pairs
//   that stay non-complementary longer than the skew budget and counts
//   those events.
//
//   Build option: define PRIM_ALERT_LINK_MONITOR_EN to build the monitor.
//   Without it, sigint_o and sigint_cnt_o are tied to 0 and clr_cnt_i is
//   ignored. Delay and injection behave the same in both builds.
//
//   Wire index w (used by skew_i and err_i):
//     0 .. 4N-1  : rx wires, channel c: 4c+3 ping_p, 4c+2 ping_n,
//                  4c+1 ack_p, 4c ack_n
//     4N .. 6N-1 : tx wires, channel c: 4N+2c+1 alert_p, 4N+2c alert_n
//   Even-indexed wires are n-wires (idle 1), odd ones are p-wires (idle 0).
//
// Ports
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   alert_rx_i   rx wires from the receivers      alert_rx_o  delayed, to senders
//   alert_tx_i   tx wires from the senders        alert_tx_o  delayed, to receivers
//   skew_i       per-wire skew code, skew_i[w*SkW +: SkW]; delay = code+1
//   err_i        per-wire XOR applied at the output
//   clr_cnt_i    clears all event counters
//   sigint_o     per-channel signal-integrity failure flag
//   sigint_cnt_o per-channel saturating event counters, CntW bits each
module prim_alert_link_skew #(
   parameter int NumAlerts = 4,
   parameter int MaxSkew   = 3,
   parameter int CntW      = 8,
   localparam int SkW      = (MaxSkew > 0) ? $clog2(MaxSkew + 1) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [4*NumAlerts-1:0]      alert_rx_i,
   output logic [4*NumAlerts-1:0]      alert_rx_o,
   input  logic [2*NumAlerts-1:0]      alert_tx_i,
   output logic [2*NumAlerts-1:0]      alert_tx_o,
   input  logic [6*NumAlerts*SkW-1:0]  skew_i,
   input  logic [6*NumAlerts-1:0]      err_i,
   input  logic                        clr_cnt_i,
   output logic [NumAlerts-1:0]        sigint_o,
   output logic [NumAlerts*CntW-1:0]   sigint_cnt_o
);

   localparam int NR = 4 * NumAlerts;
   localparam int NW = 6 * NumAlerts;
   localparam int D  = MaxSkew + 1;

   logic [NW-1:0] in_w, out_w;
   assign in_w = {alert_tx_i, alert_rx_i};

   // ---------------- per-wire delay lines ----------------
   for (genvar w = 0; w < NW; w++) begin : g_wire
      localparam logic RstVal = ((w % 2) == 0);
      logic [MaxSkew:0] sr_q, sr_d;
      logic [SkW-1:0]   code, tap;

      assign code = skew_i[w*SkW +: SkW];
      // Out-of-range codes use the deepest stage.
      assign tap  = (int'(code) > MaxSkew) ? SkW'(MaxSkew) : code;

      always_comb begin
         sr_d    = sr_q;
         sr_d[0] = in_w[w];
         for (int i = 1; i <= MaxSkew; i++) sr_d[i] = sr_q[i-1];
      end

      always_ff @(posedge clk_i) begin
         if (!rst_ni) sr_q <= {D{RstVal}};
         else         sr_q <= sr_d;
      end

      // Tap and injection are combinational so stress tests can switch
      // them on any cycle (data may be dropped or repeated).
      assign out_w[w] = sr_q[tap] ^ err_i[w];
   end

   assign alert_rx_o = out_w[NR-1:0];
   assign alert_tx_o = out_w[NW-1:NR];

`ifdef PRIM_ALERT_LINK_MONITOR_EN
   // ---------------- signal-integrity monitor ----------------
   localparam int EqW = $clog2(MaxSkew + 2);

   for (genvar c = 0; c < NumAlerts; c++) begin : g_mon
      // Pair order: 0 ack, 1 ping, 2 alert.
      logic [2:0]          pp, pn, fail;
      logic [2:0][EqW-1:0] eq_q, eq_d;
      logic                sig_q, sig_d, rise_q;
      logic [CntW-1:0]     cnt_q, cnt_d;

      assign pp = {out_w[NR+2*c+1], out_w[4*c+3], out_w[4*c+1]};
      assign pn = {out_w[NR+2*c],   out_w[4*c+2], out_w[4*c]};

      always_comb begin
         eq_d = '0;
         fail = '0;
         for (int j = 0; j < 3; j++) begin
            fail[j] = (eq_q[j] == EqW'(D));
            if (pp[j] == pn[j]) eq_d[j] = fail[j] ? eq_q[j] : eq_q[j] + 1'b1;
         end
         sig_d = |fail;
         // rise_q marks that sigint rose on the previous edge; a clear
         // in the same cycle wins and the event is lost.
         cnt_d = cnt_q;
         if (clr_cnt_i)                     cnt_d = '0;
         else if (rise_q && (cnt_q != '1))  cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            eq_q   <= '0;
            sig_q  <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            eq_q   <= eq_d;
            sig_q  <= sig_d;
            rise_q <= sig_d & ~sig_q;
            cnt_q  <= cnt_d;
         end
      end

      assign sigint_o[c]                  = sig_q;
      assign sigint_cnt_o[c*CntW +: CntW] = cnt_q;
   end
`else
   logic unused_clr_cnt;
   assign unused_clr_cnt = clr_cnt_i;
   assign sigint_o       = '0;
   assign sigint_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_prim_alert_link_skew.sv
module tb_prim_alert_link_skew;

   localparam int N    = 3;
   localparam int M    = 3;
   localparam int CW   = 2;
   localparam int SkW  = 2;
   localparam int NR   = 4 * N;
   localparam int NT   = 2 * N;
   localparam int NW   = 6 * N;
   localparam int SKB  = NW * SkW;
   localparam int CMAX = (1 << CW) - 1;
`ifdef PRIM_ALERT_LINK_MONITOR_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif
   localparam logic [NR-1:0] IDLE_RX = {N{4'b0101}};
   localparam logic [NT-1:0] IDLE_TX = {N{2'b01}};

   logic              clk, rst_n, clr;
   logic [NR-1:0]     rx_i, rx_o;
   logic [NT-1:0]     tx_i, tx_o;
   logic [SKB-1:0]    skew;
   logic [NW-1:0]     err;
   logic [N-1:0]      sig;
   logic [N*CW-1:0]   cnt;

   int total = 0;
   int bad   = 0;

   prim_alert_link_skew #(.NumAlerts(N), .MaxSkew(M), .CntW(CW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .alert_rx_i(rx_i), .alert_rx_o(rx_o),
      .alert_tx_i(tx_i), .alert_tx_o(tx_o),
      .skew_i(skew), .err_i(err), .clr_cnt_i(clr),
      .sigint_o(sig), .sigint_cnt_o(cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Delay: the output of a wire with code k is the input sampled k edges
   // before the most recent edge, or the idle level if that sample predates
   // the last reset edge. Monitor: run lengths of equal output cycles.
   logic [NW-1:0] in_log[$];
   int last_rst = 0;
   int run  [3*N];
   bit msig [N];
   bit rose [N];
   int mcnt [N];

   function automatic logic [NW-1:0] m_out();
      logic [NW-1:0] r, tmp;
      int t, k, idx;
      t = in_log.size() - 1;
      for (int w = 0; w < NW; w++) begin
         k = int'(skew[w*SkW +: SkW]);
         if (k > M) k = M;
         idx = t - k;
         if (idx > last_rst) begin
            tmp  = in_log[idx];
            r[w] = tmp[w];
         end else begin
            r[w] = ((w % 2) == 0);
         end
         r[w] = r[w] ^ err[w];
      end
      return r;
   endfunction

   function automatic int pw(int c, int j);
      if (j == 0) return 4*c + 3;
      if (j == 1) return 4*c + 1;
      return NR + 2*c + 1;
   endfunction

   function automatic logic [N-1:0] m_sig();
      logic [N-1:0] r;
      for (int c = 0; c < N; c++) r[c] = MON & msig[c];
      return r;
   endfunction

   function automatic logic [N*CW-1:0] m_cnt();
      logic [N*CW-1:0] r;
      for (int c = 0; c < N; c++) r[c*CW +: CW] = MON ? CW'(mcnt[c]) : '0;
      return r;
   endfunction

   // One clock: stimulus already set at the falling edge; returns at the
   // next falling edge with the model advanced.
   task automatic cyc();
      logic [NW-1:0] o;
      bit ns;
      o = m_out();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 3*N; i++) run[i] = 0;
         for (int c = 0; c < N; c++) begin
            msig[c] = 0; rose[c] = 0; mcnt[c] = 0;
         end
      end else begin
         for (int c = 0; c < N; c++) begin
            ns = 0;
            for (int j = 0; j < 3; j++) if (run[3*c+j] == M+1) ns = 1;
            if (clr) mcnt[c] = 0;
            else if (rose[c] && mcnt[c] < CMAX) mcnt[c]++;
            rose[c] = ns && !msig[c];
            msig[c] = ns;
            for (int j = 0; j < 3; j++) begin
               if (o[pw(c,j)] == o[pw(c,j)-1])
                  run[3*c+j] = (run[3*c+j] == M+1) ? M+1 : run[3*c+j] + 1;
               else
                  run[3*c+j] = 0;
            end
         end
      end
      in_log.push_back({tx_i, rx_i});
      if (!rst_n) last_rst = in_log.size() - 1;
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 0; err = '0; clr = 0;
      skew = SKB'({$urandom, $urandom});
      rx_i = NR'($urandom); tx_i = NT'($urandom);
      repeat (2) cyc();
      total++; if (rx_o !== IDLE_RX) begin bad++; $display("FAIL reset_rx got=%h exp=%h", rx_o, IDLE_RX); end
      total++; if (tx_o !== IDLE_TX) begin bad++; $display("FAIL reset_tx got=%h exp=%h", tx_o, IDLE_TX); end
      total++; if (sig !== '0) begin bad++; $display("FAIL reset_sig got=%h exp=0", sig); end
      total++; if (cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
      rst_n = 1; rx_i = IDLE_RX; tx_i = IDLE_TX; skew = '0;
      repeat (4) begin
         cyc();
         total++; if ({tx_o, rx_o} !== m_out()) begin bad++; $display("FAIL reset_idle got=%h exp=%h", {tx_o, rx_o}, m_out()); end
      end
   endtask

   task automatic test_delay(int k);
      logic [NR-1:0] exp_rx;
      skew = '0; skew[SkW-1:0] = SkW'(k); err = '0;
      rx_i = IDLE_RX; tx_i = IDLE_TX;
      repeat (M + 2) cyc();
      rx_i[0] = 1'b0;
      cyc();
      rx_i[0] = 1'b1;
      for (int j = 0; j <= 6; j++) begin
         exp_rx = IDLE_RX;
         if (j == k) exp_rx[0] = 1'b0;
         total++; if (rx_o !== exp_rx) begin bad++; $display("FAIL delay_k%0d_j%0d got=%h exp=%h", k, j, rx_o, exp_rx); end
         total++; if (tx_o !== IDLE_TX) begin bad++; $display("FAIL delay_tx_k%0d got=%h exp=%h", k, tx_o, IDLE_TX); end
         cyc();
      end
   endtask

   task automatic test_random(int n);
      clr = 0; err = '0;
      for (int i = 0; i < n; i++) begin
         rx_i = NR'($urandom); tx_i = NT'($urandom);
         if ($urandom_range(0, 3) == 0) skew = SKB'({$urandom, $urandom});
         if ($urandom_range(0, 9) == 0) err[$urandom_range(0, NW-1)] ^= 1'b1;
         clr = ($urandom_range(0, 15) == 0);
         cyc();
         total++; if ({tx_o, rx_o} !== m_out()) begin bad++; $display("FAIL rand_out i=%0d got=%h exp=%h", i, {tx_o, rx_o}, m_out()); end
         total++; if (sig !== m_sig()) begin bad++; $display("FAIL rand_sig i=%0d got=%h exp=%h", i, sig, m_sig()); end
         total++; if (cnt !== m_cnt()) begin bad++; $display("FAIL rand_cnt i=%0d got=%h exp=%h", i, cnt, m_cnt()); end
      end
      clr = 0; err = '0;
   endtask

   task automatic test_legal_skew();
      logic pv;
      rx_i = IDLE_RX; tx_i = IDLE_TX; err = '0; clr = 0; skew = '0;
      repeat (M + 3) cyc();
      skew[(NR+3)*SkW +: SkW] = 2'd3;   // ch1 alert_p
      skew[(NR+2)*SkW +: SkW] = 2'd0;   // ch1 alert_n
      pv = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (i % 6 == 0) pv = ~pv;
         tx_i[3] = pv; tx_i[2] = ~pv;
         cyc();
         total++; if (sig !== '0) begin bad++; $display("FAIL legal_sig i=%0d got=%h exp=0", i, sig); end
         total++; if (tx_o !== m_out() >> NR) begin bad++; $display("FAIL legal_tx i=%0d got=%h", i, tx_o); end
      end
      tx_i = IDLE_TX; skew = '0;
      repeat (M + 3) cyc();
   endtask

   task automatic test_fault();
      logic es;
      logic [CW-1:0] ec;
      rx_i = IDLE_RX; tx_i = IDLE_TX; skew = '0; err = '0;
      clr = 1; cyc(); clr = 0;
      repeat (5) cyc();
      err[2] = 1'b1;                     // ch0 ping_n
      for (int i = 1; i <= 10; i++) begin
         cyc();
         es = MON && (i >= 5) && (i <= 7);
         ec = (MON && i >= 6) ? CW'(1) : CW'(0);
         total++; if (sig[0] !== es) begin bad++; $display("FAIL fault_sig edge=%0d got=%b exp=%b", i, sig[0], es); end
         total++; if (cnt[CW-1:0] !== ec) begin bad++; $display("FAIL fault_cnt edge=%0d got=%0d exp=%0d", i, cnt[CW-1:0], ec); end
         total++; if (sig !== m_sig() || cnt !== m_cnt()) begin bad++; $display("FAIL fault_model edge=%0d got=%h/%h exp=%h/%h", i, sig, cnt, m_sig(), m_cnt()); end
         if (i == 6) err[2] = 1'b0;
      end
   endtask

   task automatic test_sat_clear();
      logic es;
      logic [CW-1:0] ec;
      rx_i = IDLE_RX; tx_i = IDLE_TX; skew = '0; err = '0;
      clr = 1; cyc(); clr = 0;
      repeat (5) cyc();
      for (int ev = 1; ev <= 6; ev++) begin
         err[8] = 1'b1;                  // ch2 ack_n
         for (int i = 1; i <= 7; i++) begin
            if (ev == 6 && i == 6) clr = 1;
            cyc();
            clr = 0;
            if (i == 5) err[8] = 1'b0;
            es = MON && (i == 5 || i == 6);
            total++; if (sig[2] !== es) begin bad++; $display("FAIL sat_sig ev=%0d edge=%0d got=%b exp=%b", ev, i, sig[2], es); end
            total++; if (cnt !== m_cnt()) begin bad++; $display("FAIL sat_model ev=%0d edge=%0d got=%h exp=%h", ev, i, cnt, m_cnt()); end
         end
         repeat (3) cyc();
         ec = MON ? ((ev < 6) ? CW'((ev < CMAX) ? ev : CMAX) : CW'(0)) : CW'(0);
         total++; if (cnt[2*CW +: CW] !== ec) begin bad++; $display("FAIL sat_cnt ev=%0d got=%0d exp=%0d", ev, cnt[2*CW +: CW], ec); end
      end
   endtask

   task automatic test_midstream_reset();
      rx_i = IDLE_RX; tx_i = IDLE_TX; err = '0; clr = 0;
      skew = {NW{2'b11}};
      repeat (5) cyc();
      for (int i = 0; i < 3; i++) begin
         rx_i = IDLE_RX ^ NR'($urandom_range(1, (1 << NR) - 1));
         tx_i = IDLE_TX ^ NT'($urandom_range(1, (1 << NT) - 1));
         cyc();
      end
      rst_n = 0; rx_i = IDLE_RX; tx_i = IDLE_TX;
      cyc();
      total++; if ({tx_o, rx_o} !== {IDLE_TX, IDLE_RX}) begin bad++; $display("FAIL mid_rst got=%h exp=%h", {tx_o, rx_o}, {IDLE_TX, IDLE_RX}); end
      rst_n = 1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         total++; if ({tx_o, rx_o} !== {IDLE_TX, IDLE_RX}) begin bad++; $display("FAIL mid_stale i=%0d got=%h exp=%h", i, {tx_o, rx_o}, {IDLE_TX, IDLE_RX}); end
         total++; if ({tx_o, rx_o} !== m_out()) begin bad++; $display("FAIL mid_model i=%0d got=%h exp=%h", i, {tx_o, rx_o}, m_out()); end
      end
   endtask

   initial begin
      rst_n = 0; clr = 0; err = '0; skew = '0; rx_i = IDLE_RX; tx_i = IDLE_TX;
      in_log.push_back({IDLE_TX, IDLE_RX});
      @(negedge clk);
      test_reset();
      test_delay(2);
      test_delay(3);
      test_legal_skew();
      test_fault();
      test_sat_clear();
      test_random(400);
      test_midstream_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
